// File: rtl/serial2parallel_param.sv
// Serial-to-parallel frame collector: gathers DEPTH words of WIDTH bits behind valid/ready handshakes.
// Optional partial-frame flush is compiled in with `define S2P_FLUSH_EN.
module serial2parallel_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
`ifdef S2P_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DEPTH*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          count,
  output logic                   done
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          count_r, count_s;
  logic [DEPTH*WIDTH-1:0] data_r, data_s;
  logic                   valid_r;
  logic                   done_r, done_s;
  logic                   in_beat_s, out_beat_s, flush_s;

`ifdef S2P_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // A held frame only makes room when the consumer takes it this cycle.
  assign in_ready   = (state_r == FULL) ? out_ready : 1'b1;
  assign in_beat_s  = in_valid & in_ready;
  assign out_beat_s = valid_r & out_ready;

  // Next-state, slot write and done-pulse computation.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    data_s  = data_r;
    done_s  = 1'b0;
    if (clear) begin
      state_s = FILL;
      count_s = {CW{1'b0}};
    end else begin
      case (state_r)
        FILL: begin
          if (in_beat_s) begin
            data_s[int'(count_r)*WIDTH +: WIDTH] = in_data;
            count_s = count_r + CW'(1);
            state_s = (count_r == CW'(DEPTH - 1)) ? FULL : FILL;
          end else begin
            count_s = count_r;
            state_s = FILL;
          end
          // A flush closes the frame at its current length and zero-fills the tail.
          if (flush_s && (state_s == FILL) && (count_s != {CW{1'b0}})) begin
            state_s = FULL;
            for (int k = 0; k < DEPTH; k++) begin
              data_s[k*WIDTH +: WIDTH] = (CW'(k) >= count_s) ? {WIDTH{1'b0}}
                                                             : data_s[k*WIDTH +: WIDTH];
            end
          end else begin
            state_s = state_s;
          end
        end
        FULL: begin
          if (out_beat_s) begin
            done_s = 1'b1;
            if (in_beat_s) begin
              data_s[WIDTH-1:0] = in_data;
              count_s = CW'(1);
              state_s = (DEPTH == 1) ? FULL : FILL;
            end else begin
              count_s = {CW{1'b0}};
              state_s = FILL;
            end
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = FILL;
          count_s = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, frame storage and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FILL;
      count_r <= {CW{1'b0}};
      data_r  <= {(DEPTH*WIDTH){1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      data_r  <= data_s;
      valid_r <= (state_s == FULL);
      done_r  <= done_s;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign count     = count_r;
  assign done      = done_r;

endmodule

// File: doc/serial2parallel_param.md
Name: serial2parallel_param

Overview:
Parametrised serial-to-parallel collector for the perceptron datapath.
- Accepts one WIDTH-bit word per valid/ready beat and assembles DEPTH words into one parallel frame.
- Presents the frame on a flat bus with its own valid/ready handshake.
- Generalises the fixed 10×32 start-gated shifter with back-pressure, framing, word count and a frame-done pulse.

Parameters:
WIDTH, 32, bits per input word
DEPTH, 10, words per frame (≥1)
CW, $clog2(DEPTH+1), width of word counter (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous frame abort, discards partial/held frame
in_data  input  WIDTH  serial input word
in_valid  input  1  in_data valid
in_ready  output  1  collector can accept a word
out_data  output  DEPTH*WIDTH  frame; word k at bits [k*WIDTH +: WIDTH], word 0 = first received
out_valid  output  1  frame complete and held
out_ready  input  1  consumer accepts frame
count  output  CW  words currently captured (0..DEPTH)
done  output  1  one-cycle pulse on the cycle after a frame handshake

Behaviour:
- Reset (rst_n=0 at clk edge): state=FILL, count=0, out_data=0, out_valid=0, done=0. Reset overrides clear and all handshakes.
- Input beat: in_valid & in_ready.
- Output beat: out_valid & out_ready.
- FILL state:
  - in_ready=1, out_valid=0.
  - On an input beat, in_data is written into slot count and count increments.
  - When count reaches DEPTH (beat with count==DEPTH-1), next state is FULL, count=DEPTH, out_valid=1 on the next cycle.
  - Latency from last word beat to out_valid is 1 cycle.
- FULL state:
  - out_valid=1; out_data and count are stable until the output beat.
  - in_ready = out_ready (combinational pass-through).
  - Output beat without input beat: state=FILL, count=0.
  - Output beat with input beat in the same cycle: state=FILL, in_data goes to slot 0, count=1 (no bubble).
  - If DEPTH==1, output and input beats together keep FULL with the new word in slot 0.
- done: registered; 1 for exactly one cycle following each output beat, 0 otherwise.
- Slot contents: slots ≥ count hold stale data and are not zeroed between frames. Only the valid frame is defined.
- clear=1 (rst_n=1):
  - Next state is FILL, count=0, out_valid=0, no done pulse.
  - Any input or output beat in the same cycle is ignored: the word is dropped and the frame is not delivered.
  - out_data is not zeroed.
- in_valid while in_ready=0: the word is not captured. The producer must hold it; no overflow is possible.
- count never exceeds DEPTH; it wraps only via output beat, clear or reset.

Optional Feature:
Macro S2P_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 in FILL with count>0 and no input beat: next state is FULL, out_valid=1, and count holds the partial length.
  - Unwritten slots of that partial frame are driven 0 on out_data. Zero-fill is applied at the flush transition.
  - flush with an input beat in the same cycle: the word is captured first, then the frame is flushed with count+1.
  - flush with count==0, in FULL, or under clear/reset: ignored.
- Not defined: port absent; frames complete only at DEPTH words.

Test Plan:
- Reset, then stream 10 words 0x1..0xA back-to-back with out_ready=1 → out_valid=1 one cycle after the 10th beat; word0=0x1, word9=0xA; count=10; done pulses 1 cycle after the output beat.
- Hold out_ready=0 after a full frame, drive in_valid=1 with 0xBB → in_ready=0, frame unchanged for 5 cycles. Raise out_ready → 0xBB lands in slot 0, count=1, no dead cycle.
- DEPTH=1, WIDTH=8, continuous in_valid/out_ready with 0x11,0x22,0x33 → one frame per cycle, out_data follows 1 cycle behind, done every cycle.
- Capture 4 words, assert clear with in_valid=1 (0xFF) → count=0, out_valid=0, 0xFF dropped; next 10 words form a clean frame.
- Assert rst_n=0 for one cycle mid-frame (count=7) and while FULL → all outputs return to reset values on that edge; in_ready=1 next cycle.
- With S2P_FLUSH_EN: capture 3 words 0xA,0xB,0xC, pulse flush → out_valid=1, count=3, slots 3..9 =0. Flush at count=0 → no effect.
